// File: rtl/regfile_writeback.sv
// Register-file write-port driver: a small result queue from MEM/WB plus a
// per-register in-flight scoreboard that decode queries before issuing.
module regfile_writeback #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_data,
    input  logic        hold,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic [4:0]  q_addr1,
    output logic        q_busy1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy2,
    output logic        sb_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [PTR_W:0]     count_q;
    logic               we_q;
    logic [4:0]         waddr_q;
    logic [31:0]        wdata_q;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];

    logic   push, pop, inc;
    entry_t head;

    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !hold;
    assign head     = mem_q[head_q];

    assign iss_stall = (iss_rd != 5'd0) && (cnt_q[iss_rd] == CNT_MAX);
    assign inc       = iss_valid && (iss_rd != 5'd0) && !iss_stall;

    // A final in-flight write is forwarded by the register file in its commit
    // cycle, so it no longer counts as busy.
    assign q_busy1 = (q_addr1 != 5'd0) && (cnt_q[q_addr1] != '0) &&
                     !(we_q && waddr_q == q_addr1 && cnt_q[q_addr1] == CNT_ONE);
    assign q_busy2 = (q_addr2 != 5'd0) && (cnt_q[q_addr2] != '0) &&
                     !(we_q && waddr_q == q_addr2 && cnt_q[q_addr2] == CNT_ONE);

    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign sb_err = err_q;

    always_comb begin
        // NOTE: defaults first so every path assigns cnt_d/err_d and no latch is inferred.
        cnt_d = cnt_q;
        err_d = err_q;
        if (iss_valid && iss_stall)
            err_d = 1'b1;
        if (we_q && !(inc && iss_rd == waddr_q)) begin
            if (cnt_q[waddr_q] == '0)
                err_d = 1'b1;
            else
                cnt_d[waddr_q] = cnt_q[waddr_q] - CNT_ONE;
        end
        if (inc && !(we_q && iss_rd == waddr_q))
            cnt_d[iss_rd] = cnt_q[iss_rd] + CNT_ONE;
        cnt_d[0] = '0;
    end

    // NOTE: queue storage is not reset; head/tail/count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[tail_q] <= '{rd: in_rd, data: in_data};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= '0;
        end else begin
            if (push)
                tail_q <= tail_q + PTR_W'(1);
            if (pop)
                head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            we_q <= pop && (head.rd != 5'd0);
            if (pop && head.rd != 5'd0) begin
                waddr_q <= head.rd;
                wdata_q <= head.data;
            end
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a scoreboard queue holds expected
// register-file writes, and a monitor compares them whenever we is high.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        hold;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_stall;
    logic [4:0]  q_addr1, q_addr2;
    logic        q_busy1, q_busy2;
    logic        sb_err;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    regfile_writeback #(.DEPTH(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .hold      (hold),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .q_addr1   (q_addr1),
        .q_busy1   (q_busy1),
        .q_addr2   (q_addr2),
        .q_busy2   (q_busy2),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a push and record the write it should eventually produce.
    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        if (rd != 5'd0)
            exp_q.push_back('{rd: rd, data: data});
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {27'd0, waddr}, {27'd0, e.rd});
                check("write_data", wdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; hold = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; q_addr1 = 5'd5; q_addr2 = 5'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {27'd0, waddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy1", {31'd0, q_busy1}, 32'd0);
        check("rst_busy2", {31'd0, q_busy2}, 32'd0);
        check("rst_sb_err", {31'd0, sb_err}, 32'd0);

        // Single in-flight write to r5
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        #1 check("r5_busy_after_issue", {31'd0, q_busy1}, 32'd1);
        tick();
        check("r5_busy_wait", {31'd0, q_busy1}, 32'd1);
        tick();
        push(5'd5, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0;
        #1 check("r5_busy_queued", {31'd0, q_busy1}, 32'd1);
        tick();
        check("r5_commit_we", {31'd0, we}, 32'd1);
        check("r5_commit_not_busy", {31'd0, q_busy1}, 32'd0);
        tick();
        check("r5_after_we", {31'd0, we}, 32'd0);
        check("r5_after_busy", {31'd0, q_busy1}, 32'd0);
        check("r5_no_err", {31'd0, sb_err}, 32'd0);

        // Hold with a full queue, then drain on consecutive cycles
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd4;
        tick();
        iss_valid = 1'b0;
        hold = 1'b1;
        push(5'd3, 32'h11);
        tick();
        push(5'd4, 32'h22);
        tick();
        in_rd = 5'd8; in_data = 32'h33;
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_we", {31'd0, we}, 32'd0);
        tick();
        check("full_hold_we", {31'd0, we}, 32'd0);
        check("full_still", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; hold = 1'b0;
        tick();
        check("drain1_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain1_we", {31'd0, we}, 32'd1);
        tick();
        check("drain2_we", {31'd0, we}, 32'd1);
        tick();
        q_addr1 = 5'd3; q_addr2 = 5'd4;
        #1;
        check("drain_done_we", {31'd0, we}, 32'd0);
        check("r3_idle", {31'd0, q_busy1}, 32'd0);
        check("r4_idle", {31'd0, q_busy2}, 32'd0);
        check("drain_no_err", {31'd0, sb_err}, 32'd0);

        // Saturate r7's counter
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1 check("r7_no_stall_at_0", {31'd0, iss_stall}, 32'd0);
        tick(); tick(); tick();
        check("r7_stall_at_max", {31'd0, iss_stall}, 32'd1);
        check("r7_err_before_overflow", {31'd0, sb_err}, 32'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        check("r7_overflow_err", {31'd0, sb_err}, 32'd1);
        check("r7_count_held", {31'd0, iss_stall}, 32'd1);

        // r0 results are discarded; waddr/wdata keep the last write
        push(5'd0, 32'h1234);
        tick();
        in_valid = 1'b0;
        tick();
        check("r0_no_we", {31'd0, we}, 32'd0);
        check("r0_waddr_kept", {27'd0, waddr}, 32'd4);
        check("r0_wdata_kept", wdata, 32'h22);
        tick();
        check("r0_no_we_later", {31'd0, we}, 32'd0);

        // Clear, then a commit to untracked r9 underflows
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_sb_err", {31'd0, sb_err}, 32'd0);
        check("rst2_r7_cleared", {31'd0, iss_stall}, 32'd0);
        push(5'd9, 32'h99);
        tick();
        in_valid = 1'b0;
        tick();
        check("r9_commit_we", {31'd0, we}, 32'd1);
        tick();
        check("r9_underflow_err", {31'd0, sb_err}, 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_addr1 = 5'd6; q_addr2 = 5'd12;

        // Issue r6 during r6's final commit: counter stays 1
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        iss_valid = 1'b0;
        push(5'd6, 32'h66);
        tick();
        in_valid = 1'b0;
        tick();
        check("r6_commit_we", {31'd0, we}, 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd6;
        #1;
        check("r6_no_stall", {31'd0, iss_stall}, 32'd0);
        check("r6_commit_not_busy", {31'd0, q_busy1}, 32'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        check("r6_busy_after_overlap", {31'd0, q_busy1}, 32'd1);
        check("r6_no_err", {31'd0, sb_err}, 32'd0);

        // Reset with queued entries flushes everything
        iss_valid = 1'b1; iss_rd = 5'd12;
        hold = 1'b1;
        push(5'd10, 32'hA);
        tick();
        iss_valid = 1'b0;
        push(5'd11, 32'hB);
        tick();
        in_valid = 1'b0;
        #1 check("r12_busy", {31'd0, q_busy2}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b0;
        exp_q.delete();
        #1;
        check("flush_we", {31'd0, we}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_r6_idle", {31'd0, q_busy1}, 32'd0);
        check("flush_r12_idle", {31'd0, q_busy2}, 32'd0);
        tick();
        check("flush_no_write", {31'd0, we}, 32'd0);
        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
